// File: rtl/iter_ashr_unit.sv
// Iterative arithmetic right shifter: accepts a signed word and a shift amount,
// shifts one bit per clock with sign fill, then holds the result until consumed.
module iter_ashr_unit #(
    parameter int DATA_W  = 7,
    parameter int SHAMT_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_x,
    input  logic [SHAMT_W-1:0] shift_mag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_x,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(0);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
    localparam logic [DATA_W-1:0]  DATA_ZERO = DATA_W'(0);

    state_t             state_r;
    state_t             state_s;
    logic [DATA_W-1:0]  data_r;
    logic [DATA_W-1:0]  data_s;
    logic [SHAMT_W-1:0] cnt_r;
    logic [SHAMT_W-1:0] cnt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    // Next-state and datapath update for the shift sequencer.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    data_s = in_x;
                    cnt_s  = shift_mag;
                    if (shift_mag == CNT_ZERO) begin
                        state_s = HOLD;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                data_s = {data_r[DATA_W-1], data_r[DATA_W-1:1]};
                cnt_s  = cnt_r - CNT_ONE;
                // Leaving at cnt_r == 1 keeps the counter from ever wrapping.
                if (cnt_r == CNT_ONE) begin
                    state_s = HOLD;
                end else begin
                    state_s = SHIFT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
                data_s  = DATA_ZERO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and handshake flags; flags are registered copies of the state decode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            data_r      <= DATA_ZERO;
            cnt_r       <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            data_r      <= data_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == HOLD);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_x     = data_r;

endmodule

// File: tb/tb_iter_ashr_unit.sv
// Directed bench for iter_ashr_unit: stimulus pushes hand-computed results into a
// scoreboard queue, an independent monitor pops and compares on each output handshake.
module tb_iter_ashr_unit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_x;
    logic [2:0] shift_mag;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_x;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [6:0] exp_q[$];

    iter_ashr_unit #(.DATA_W(7), .SHAMT_W(3)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .shift_mag (shift_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .busy      (busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare every output transfer against the scoreboard.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h with empty scoreboard", out_x);
            end else begin
                check("out_x", {25'd0, out_x}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    // Issue one operation, then wait (bounded) for out_valid and check latency == k.
    task automatic run_op(input logic [6:0] x, input logic [2:0] k, input logic [6:0] exp);
        int n;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_x      = x;
        shift_mag = k;
        exp_q.push_back(exp);
        tick();
        in_valid  = 1'b0;
        in_x      = 7'h2A;
        shift_mag = 3'd5;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, {29'd0, k});
    endtask

    // After a transfer with out_ready high: unit returns to IDLE on the next cycle.
    task automatic finish_op();
        tick();
        check("out_valid_after_xfer", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i     = 1'b1;
        in_valid  = 1'b1;
        in_x      = 7'h33;
        shift_mag = 3'd2;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_x", {25'd0, out_x}, 32'd0);
        rst_i    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Negative operand: -64 >>> 3 = -8
        run_op(7'b1000000, 3'd3, 7'b1111000);
        finish_op();
        // Positive operands, including zero shift
        run_op(7'd45, 3'd2, 7'd11);
        finish_op();
        run_op(7'd45, 3'd0, 7'd45);
        finish_op();
        // Oversized shifts collapse to the sign
        run_op(7'b1010101, 3'd7, 7'h7F);
        finish_op();
        run_op(7'd63, 3'd7, 7'd0);
        finish_op();
        // Floor rounding: -43 >>> 1 = -22
        run_op(7'b1010101, 3'd1, 7'b1101010);
        finish_op();

        // Backpressure: 20 >>> 1 = 10 held while out_ready is low
        out_ready = 1'b0;
        run_op(7'd20, 3'd1, 7'd10);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = 7'd99;
            shift_mag = 3'd0;
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_x", {25'd0, out_x}, 32'd10);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_op();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_single_xfer", {31'd0, out_valid}, 32'd0);
        end
        check("bp_queue_empty", exp_q.size(), 32'd0);

        // Reset mid-operation discards the result
        in_valid  = 1'b1;
        in_x      = 7'b1000000;
        shift_mag = 3'd5;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_out_x", {25'd0, out_x}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(7'd8, 3'd3, 7'd1);
        finish_op();

        tick();
        tick();
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_ashr_unit.md
Name: iter_ashr_unit

Overview:
- Iterative arithmetic right shifter with valid/ready handshakes on input and output.
- It is the opposite-direction companion to the existing registered single-cycle left-shift stage in the fixed-point datapath.
- It shifts a signed word right by a run-time amount, one bit position per clock, and sign-extends from the MSB.
- Intended for area-constrained scaling steps where the latency of a multi-cycle shift is acceptable.

Parameters:
- DATA_W, 7, width of the data word, two's complement.
- SHAMT_W, 3, width of the shift-amount field.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous and active-high.
- in_valid  input  1  in_x and shift_mag are valid.
- in_ready  output  1  unit can accept a new operand.
- in_x  input  DATA_W  signed operand.
- shift_mag  input  SHAMT_W  unsigned shift amount k.
- out_valid  output  1  out_x holds the finished result.
- out_ready  input  1  downstream consumes the result.
- out_x  output  DATA_W  result, in_x >>> k (sign-filled).
- busy  output  1  high in SHIFT or HOLD.

Behaviour:
- States: IDLE, SHIFT, HOLD. Internal registers: data_r (DATA_W bits) and cnt_r (SHAMT_W bits).
- Outputs are decoded from state:
  - in_ready = (state == IDLE)
  - out_valid = (state == HOLD)
  - busy = (state != IDLE)
  - out_x = data_r at all times
- Reset (rst_i high at an edge):
  - state becomes IDLE; data_r and cnt_r become 0.
  - After reset: in_ready = 1, out_valid = 0, busy = 0, out_x = 0.
  - Reset has priority over every other event. Reset in SHIFT or HOLD discards the operation; no out_valid pulse follows.
- IDLE:
  - An edge with in_valid = 1 is the accept edge T. At T: data_r <= in_x, cnt_r <= shift_mag.
  - Next state is HOLD if shift_mag = 0, otherwise SHIFT.
  - in_valid = 0: remain in IDLE; registers hold.
- SHIFT:
  - Each edge: data_r <= {data_r[MSB], data_r[DATA_W-1:1]} and cnt_r <= cnt_r - 1.
  - On the edge where cnt_r = 1 (the last shift), next state is HOLD.
  - in_valid is ignored; in_ready = 0.
- HOLD:
  - out_valid = 1. data_r is frozen and stable until the handshake.
  - Edge with out_ready = 1: go to IDLE. in_ready rises in the following cycle; there is no same-cycle re-accept.
  - out_ready = 0: remain in HOLD indefinitely.
- Latency: out_valid is first high in the cycle after edge T + k, so k = 0 gives one cycle and k = 7 gives eight cycles.
- Throughput: one operation per (k + 2) cycles with out_ready tied high.
- Width rules:
  - k >= DATA_W is legal. The result is all sign bits: -1 for negative inputs, 0 for non-negative.
  - No saturation or rounding; shifted-out bits are truncated (floor toward negative infinity).
- Inputs sampled only at T; in_x and shift_mag may change freely afterwards.
- out_ready is ignored outside HOLD.
- cnt_r never underflows: the SHIFT exit occurs at cnt_r = 1, and SHIFT is never entered with cnt_r = 0.

Test Plan:
1. Reset: assert rst_i for 2 cycles with in_valid = 1 -> in_ready = 1, out_valid = 0, busy = 0, out_x = 0; nothing accepted.
2. Negative operand: in_x = 7'b1000000 (-64), k = 3, out_ready = 1 -> out_valid first high in cycle T+3+1, out_x = 7'b1111000 (-8), then in_ready = 1 in the next cycle.
3. Positive operand and zero shift:
   - in_x = 7'd45, k = 2 -> out_x = 7'd11 at T+2.
   - Then in_x = 7'd45, k = 0 -> out_valid in the cycle right after T, out_x = 7'd45.
4. Oversized shift: in_x = 7'b1010101 (-43), k = 7 -> out_x = 7'h7F (-1) after edge T+7. Also in_x = 7'd63, k = 7 -> out_x = 0.
5. Backpressure: k = 1, out_ready held low for 5 cycles after out_valid rises -> out_valid stays 1 and out_x stays stable. in_valid pulses during HOLD are not accepted. Raising out_ready completes exactly one transfer.
6. Reset mid-operation: accept in_x = -64, k = 5; assert rst_i on the third SHIFT edge -> IDLE next cycle, out_x = 0, no out_valid. A following operation (in_x = 7'd8, k = 3) yields 7'd1.
